// File: rtl/vseq_pkg.sv
// Shared definitions for the vector beat sequencer: SEW encodings, FSM states
// and the beat-index width derivation.
package vseq_pkg;

  localparam logic [1:0] SEW8  = 2'b00;
  localparam logic [1:0] SEW16 = 2'b01;
  localparam logic [1:0] SEW32 = 2'b10;
  localparam logic [1:0] SEW64 = 2'b11;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Byte count needs clog2(VLMAX)+4 bits (avl up to VLMAX, shifted by up to 3);
  // one beat covers DATA_WIDTH/8 bytes.
  function automatic int beat_w(input int data_width, input int vlen);
    return $clog2(vlen >> 3) + 4 - $clog2(data_width / 8);
  endfunction

endpackage

// File: rtl/vseq_be_gen.sv
// Byte-enable mask for one beat: all lanes live, except a partial final beat
// where only the low (bytes mod BPB) lanes are live.
module vseq_be_gen #(
  parameter int DATA_WIDTH = 64
) (
  input  logic [$clog2(DATA_WIDTH/8)-1:0] i_rem,
  input  logic                            i_last,
  output logic [DATA_WIDTH/8-1:0]         o_be
);

  localparam int BPB     = DATA_WIDTH / 8;
  localparam int LOG_BPB = $clog2(BPB);

  always_comb begin
    o_be = '1;
    if (i_last && (i_rem != '0)) begin
      for (int b = 0; b < BPB; b++) begin
        o_be[b] = (LOG_BPB'(b) < i_rem);
      end
    end
  end

endmodule

// File: rtl/vl_beat_seq.sv
// Beat sequencer: turns a (avl, sew) configuration into a stream of
// DATA_WIDTH-wide beats with index, byte enables and last flag.
module vl_beat_seq
  import vseq_pkg::*;
#(
  parameter int XLEN          = 32,
  parameter int VLEN          = 16384,
  parameter int DATA_WIDTH    = 64,
  parameter int VLMAX         = VLEN >> 3,
  parameter int VLEN_B_BITS   = $clog2(VLMAX),
  parameter int ENABLE_64_BIT = 1,
  localparam int BEAT_W       = beat_w(DATA_WIDTH, VLEN)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    flush,
  input  logic [VLEN_B_BITS:0]    avl,
  input  logic [1:0]              sew,
  input  logic                    vill,
  output logic                    busy,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [BEAT_W-1:0]       out_idx,
  output logic [DATA_WIDTH/8-1:0] out_be,
  output logic                    out_last,
  output logic                    done,
  output logic                    err
);

  localparam int BPB     = DATA_WIDTH / 8;
  localparam int LOG_BPB = $clog2(BPB);
  localparam int BC_W    = VLEN_B_BITS + 4;
  localparam int BN_W    = BC_W - LOG_BPB + 1;

  if (XLEN < 1 || DATA_WIDTH < 64 || (DATA_WIDTH & (DATA_WIDTH - 1)) != 0) begin : g_bad_cfg
    $error("vl_beat_seq: DATA_WIDTH must be a power of two >= 64");
  end

  state_t                r_state;
  logic [BEAT_W-1:0]     r_idx;
  logic [BEAT_W-1:0]     r_last_idx;
  logic [LOG_BPB-1:0]    r_rem;
  logic [BPB-1:0]        r_be;
  logic                  r_last;
  logic                  r_done;
  logic                  r_err;

  logic [BC_W-1:0]       w_bytes;
  logic [BC_W:0]         w_bytes_rnd;
  logic [BN_W-1:0]       w_beats;
  logic                  w_first_last;
  logic                  w_illegal;
  logic [BEAT_W-1:0]     w_idx_inc;
  logic [LOG_BPB-1:0]    w_rem_sel;
  logic                  w_last_sel;
  logic [BPB-1:0]        w_be;

  // Byte count and ceil(bytes/BPB), only meaningful in the accept cycle.
  assign w_bytes      = BC_W'(avl) << sew;
  assign w_bytes_rnd  = {1'b0, w_bytes} + (BC_W + 1)'(BPB - 1);
  assign w_beats      = w_bytes_rnd[BC_W:LOG_BPB];
  assign w_first_last = (w_beats == BN_W'(1));
  assign w_illegal    = vill || ((sew == SEW64) && (ENABLE_64_BIT == 0));
  assign w_idx_inc    = r_idx + 1'b1;

  // The mask is computed for the beat being loaded next, then registered.
  assign w_rem_sel  = (r_state == IDLE) ? w_bytes[LOG_BPB-1:0] : r_rem;
  assign w_last_sel = (r_state == IDLE) ? w_first_last : (w_idx_inc == r_last_idx);

  vseq_be_gen #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_be_gen (
    .i_rem  (w_rem_sel),
    .i_last (w_last_sel),
    .o_be   (w_be)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_idx      <= '0;
      r_last_idx <= '0;
      r_rem      <= '0;
      r_be       <= '0;
      r_last     <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      if (flush) begin
        r_state <= IDLE;
        r_idx   <= '0;
        r_be    <= '0;
        r_last  <= 1'b0;
      end else begin
        case (r_state)
          IDLE: begin
            if (start) begin
              if (w_illegal) begin
                r_err <= 1'b1;
              end else if (avl == '0) begin
                r_done <= 1'b1;
              end else begin
                r_state    <= RUN;
                r_idx      <= '0;
                r_last_idx <= BEAT_W'(w_beats - 1'b1);
                r_rem      <= w_bytes[LOG_BPB-1:0];
                r_last     <= w_last_sel;
                r_be       <= w_be;
              end
            end
          end
          RUN: begin
            if (out_ready) begin
              if (r_last) begin
                r_state <= IDLE;
                r_done  <= 1'b1;
                r_idx   <= '0;
                r_be    <= '0;
                r_last  <= 1'b0;
              end else begin
                r_idx  <= w_idx_inc;
                r_last <= w_last_sel;
                r_be   <= w_be;
              end
            end
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign busy      = (r_state == RUN);
  assign out_valid = (r_state == RUN);
  assign out_idx   = r_idx;
  assign out_be    = r_be;
  assign out_last  = r_last;
  assign done      = r_done;
  assign err       = r_err;

endmodule

// File: tb/tb_vl_beat_seq.sv
// Self-checking bench for vl_beat_seq (DATA_WIDTH=64) with a byte-count
// reference model and randomized lengths, widths and backpressure.
module tb_vl_beat_seq;

  localparam int VLMAX  = 2048;
  localparam int BEAT_W = 12;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        start2 = 1'b0;
  logic        flush = 1'b0;
  logic [11:0] avl = '0;
  logic [1:0]  sew = '0;
  logic        vill = 1'b0;
  logic        out_ready = 1'b1;

  logic              busy, out_valid, out_last, done, err;
  logic [BEAT_W-1:0] out_idx;
  logic [7:0]        out_be;
  logic              busy2, out_valid2, out_last2, done2, err2;
  logic [BEAT_W-1:0] out_idx2;
  logic [7:0]        out_be2;

  int n_chk  = 0;
  int n_pass = 0;

  vl_beat_seq #(.DATA_WIDTH(64)) dut (
    .clk(clk), .rst(rst), .start(start), .flush(flush), .avl(avl), .sew(sew),
    .vill(vill), .busy(busy), .out_valid(out_valid), .out_ready(out_ready),
    .out_idx(out_idx), .out_be(out_be), .out_last(out_last), .done(done), .err(err)
  );

  vl_beat_seq #(.DATA_WIDTH(64), .ENABLE_64_BIT(0)) dut_n64 (
    .clk(clk), .rst(rst), .start(start2), .flush(flush), .avl(avl), .sew(sew),
    .vill(vill), .busy(busy2), .out_valid(out_valid2), .out_ready(out_ready),
    .out_idx(out_idx2), .out_be(out_be2), .out_last(out_last2), .done(done2), .err(err2)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Runs one sequence and checks every cycle against the byte-count model.
  // mode 0: ready high, 1: random ready, 2: ready low 3 cycles at beat 1,
  // 3: ready high while start and avl are churned during the run.
  task automatic run_and_check(input int a, input int s, input int mode, input string nm,
                               output int nb, output logic [7:0] lastbe);
    int bytes, beats, i, cyc, stall;
    logic [7:0] ebe;
    logic rdy;
    bytes = a * (1 << s);
    beats = (bytes + 7) / 8;
    avl = 12'(a); sew = 2'(s); vill = 1'b0; out_ready = 1'b1; start = 1'b1;
    step();
    start = 1'b0;
    i = 0; cyc = 0; stall = 0; nb = 0; lastbe = '0;
    while (i < beats && cyc < beats * 8 + 50) begin
      rdy = 1'b1;
      case (mode)
        1: rdy = 1'($urandom_range(0, 1));
        2: begin
          rdy = !(i == 1 && stall < 3);
          if (!rdy) stall++;
        end
        3: if (i >= 1) begin
          start = 1'b1;
          avl = 12'($urandom_range(1, VLMAX));
        end
        default: rdy = 1'b1;
      endcase
      out_ready = rdy;
      if (i == beats - 1 && (bytes % 8) != 0) ebe = 8'((1 << (bytes % 8)) - 1);
      else ebe = 8'hFF;
      n_chk++;
      if (out_valid !== 1'b1 || busy !== 1'b1 || out_idx !== BEAT_W'(i) || out_be !== ebe ||
          out_last !== (i == beats - 1) || done !== 1'b0 || err !== 1'b0)
        $display("FAIL %s beat: got v=%b b=%b idx=%0d be=%h last=%b done=%b err=%b, want v=1 b=1 idx=%0d be=%h last=%b done=0 err=0",
                 nm, out_valid, busy, out_idx, out_be, out_last, done, err, i, ebe, (i == beats - 1));
      else n_pass++;
      if (rdy) begin
        nb++;
        lastbe = out_be;
        i++;
      end
      step();
      cyc++;
    end
    start = 1'b0;
    out_ready = 1'b1;
    n_chk++;
    if (i != beats) $display("FAIL %s timeout: got %0d beats, want %0d", nm, i, beats);
    else n_pass++;
    n_chk++;
    if (done !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0 || err !== 1'b0)
      $display("FAIL %s done: got done=%b busy=%b v=%b err=%b, want 1 0 0 0", nm, done, busy, out_valid, err);
    else n_pass++;
    step();
    n_chk++;
    if (done !== 1'b0 || out_valid !== 1'b0)
      $display("FAIL %s done_width: got done=%b v=%b, want 0 0", nm, done, out_valid);
    else n_pass++;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step(); step();
    n_chk++;
    if (busy !== 0 || out_valid !== 0 || out_idx !== '0 || out_be !== '0 || out_last !== 0 ||
        done !== 0 || err !== 0 || busy2 !== 0 || out_valid2 !== 0)
      $display("FAIL reset: got b=%b v=%b idx=%0d be=%h last=%b done=%b err=%b, want all 0",
               busy, out_valid, out_idx, out_be, out_last, done, err);
    else n_pass++;
    rst = 1'b0;
    step();
  endtask

  task automatic test_basic();
    int nb;
    logic [7:0] lb;
    run_and_check(10, 1, 0, "basic_10x16", nb, lb);
    n_chk++;
    if (nb != 3 || lb !== 8'h0F) $display("FAIL basic_summary: got beats=%0d lastbe=%h, want 3 0f", nb, lb);
    else n_pass++;
  endtask

  task automatic test_long();
    int nb;
    logic [7:0] lb;
    run_and_check(2048, 0, 0, "long_sew8", nb, lb);
    n_chk++;
    if (nb != 256 || lb !== 8'hFF) $display("FAIL long_sew8_count: got %0d/%h, want 256/ff", nb, lb);
    else n_pass++;
    run_and_check(2048, 3, 0, "long_sew64", nb, lb);
    n_chk++;
    if (nb != 2048) $display("FAIL long_sew64_count: got %0d, want 2048", nb);
    else n_pass++;
  endtask

  task automatic test_zero();
    avl = '0; sew = 2'($urandom_range(0, 3)); start = 1'b1;
    step();
    start = 1'b0;
    n_chk++;
    if (done !== 1 || out_valid !== 0 || busy !== 0 || err !== 0)
      $display("FAIL zero_avl: got done=%b v=%b b=%b err=%b, want 1 0 0 0", done, out_valid, busy, err);
    else n_pass++;
    step();
    n_chk++;
    if (done !== 0 || out_valid !== 0)
      $display("FAIL zero_avl_after: got done=%b v=%b, want 0 0", done, out_valid);
    else n_pass++;
  endtask

  task automatic test_illegal();
    avl = 12'd5; sew = 2'd0; vill = 1'b1; start = 1'b1;
    step();
    start = 1'b0; vill = 1'b0;
    n_chk++;
    if (err !== 1 || busy !== 0 || out_valid !== 0 || done !== 0)
      $display("FAIL vill: got err=%b b=%b v=%b done=%b, want 1 0 0 0", err, busy, out_valid, done);
    else n_pass++;
    step();
    n_chk++;
    if (err !== 0 || busy !== 0) $display("FAIL vill_after: got err=%b b=%b, want 0 0", err, busy);
    else n_pass++;
    avl = 12'd4; sew = 2'd3; start2 = 1'b1;
    step();
    start2 = 1'b0;
    n_chk++;
    if (err2 !== 1 || busy2 !== 0 || done2 !== 0)
      $display("FAIL no64_reject: got err=%b b=%b done=%b, want 1 0 0", err2, busy2, done2);
    else n_pass++;
    avl = 12'd4; sew = 2'd2; out_ready = 1'b1; start2 = 1'b1;
    step();
    start2 = 1'b0;
    n_chk++;
    if (out_valid2 !== 1 || err2 !== 0 || out_idx2 !== '0 || out_last2 !== 0)
      $display("FAIL no64_sew32: got v=%b err=%b idx=%0d last=%b, want 1 0 0 0", out_valid2, err2, out_idx2, out_last2);
    else n_pass++;
    step();
    n_chk++;
    if (out_last2 !== 1 || out_be2 !== 8'hFF) $display("FAIL no64_last: got last=%b be=%h, want 1 ff", out_last2, out_be2);
    else n_pass++;
    step();
    n_chk++;
    if (done2 !== 1 || busy2 !== 0) $display("FAIL no64_done: got done=%b b=%b, want 1 0", done2, busy2);
    else n_pass++;
  endtask

  task automatic test_stall();
    int nb;
    logic [7:0] lb;
    run_and_check(5, 2, 2, "stall_20B", nb, lb);
    n_chk++;
    if (nb != 3 || lb !== 8'h0F) $display("FAIL stall_summary: got %0d/%h, want 3/0f", nb, lb);
    else n_pass++;
  endtask

  task automatic test_flush();
    int cyc;
    avl = 12'd8; sew = 2'd3; out_ready = 1'b1; start = 1'b1;
    step();
    start = 1'b0;
    cyc = 0;
    while (out_idx !== 12'd3 && cyc < 20) begin
      step();
      cyc++;
    end
    n_chk++;
    if (out_idx !== 12'd3 || out_valid !== 1) $display("FAIL flush_reach: got idx=%0d v=%b, want 3 1", out_idx, out_valid);
    else n_pass++;
    flush = 1'b1; start = 1'b1; avl = 12'd4; sew = 2'd0;
    step();
    flush = 1'b0; start = 1'b0;
    n_chk++;
    if (busy !== 0 || out_valid !== 0 || done !== 0 || err !== 0)
      $display("FAIL flush: got b=%b v=%b done=%b err=%b, want 0 0 0 0", busy, out_valid, done, err);
    else n_pass++;
    step();
    n_chk++;
    if (busy !== 0 || out_valid !== 0 || done !== 0)
      $display("FAIL flush_start_ignored: got b=%b v=%b done=%b, want 0 0 0", busy, out_valid, done);
    else n_pass++;
  endtask

  task automatic test_start_during_run();
    int nb;
    logic [7:0] lb;
    run_and_check(10, 1, 3, "start_in_run", nb, lb);
    n_chk++;
    if (nb != 3) $display("FAIL start_in_run_count: got %0d, want 3", nb);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    int pos;
    avl = 12'd10; sew = 2'd1; out_ready = 1'b1; start = 1'b1;
    step();
    for (int c = 0; c < 9; c++) begin
      pos = c % 4;
      n_chk++;
      if (out_valid !== (pos < 3) || done !== (pos == 3) || (pos < 3 && out_idx !== BEAT_W'(pos)))
        $display("FAIL b2b cycle %0d: got v=%b done=%b idx=%0d, want v=%b done=%b idx=%0d",
                 c, out_valid, done, out_idx, (pos < 3), (pos == 3), pos);
      else n_pass++;
      step();
    end
    start = 1'b0; flush = 1'b1;
    step();
    flush = 1'b0;
  endtask

  task automatic test_random();
    int a, s, nb, bytes;
    logic [7:0] lb;
    for (int k = 0; k < 24; k++) begin
      a = ($urandom_range(0, 7) == 0) ? $urandom_range(1, VLMAX) : $urandom_range(1, 40);
      s = $urandom_range(0, 3);
      bytes = a * (1 << s);
      run_and_check(a, s, 1, "random", nb, lb);
      n_chk++;
      if (nb != (bytes + 7) / 8) $display("FAIL random_count avl=%0d sew=%0d: got %0d, want %0d", a, s, nb, (bytes + 7) / 8);
      else n_pass++;
    end
  endtask

  task automatic test_rst_mid();
    avl = 12'd100; sew = 2'd3; out_ready = 1'b1; start = 1'b1;
    step();
    start = 1'b0;
    step(); step();
    #2 rst = 1'b1;
    #1;
    n_chk++;
    if (busy !== 0 || out_valid !== 0 || out_idx !== '0 || out_be !== '0 || out_last !== 0 || done !== 0 || err !== 0)
      $display("FAIL rst_mid: got b=%b v=%b idx=%0d be=%h last=%b done=%b err=%b, want all 0",
               busy, out_valid, out_idx, out_be, out_last, done, err);
    else n_pass++;
    #1 rst = 1'b0;
    step();
    n_chk++;
    if (busy !== 0 || out_valid !== 0) $display("FAIL rst_mid_after: got b=%b v=%b, want 0 0", busy, out_valid);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_long();
    test_zero();
    test_illegal();
    test_stall();
    test_flush();
    test_start_during_run();
    test_back_to_back();
    test_random();
    test_rst_mid();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/vl_beat_seq.md
# vl_beat_seq

Beat sequencer directly downstream of the vector configuration unit. It consumes the registered `avl`/`sew`/`vill` configuration, and on each `start` it walks the active vector length as a sequence of DATA_WIDTH-wide beats. Each beat carries a beat index, a byte-enable mask and a last flag over a valid/ready handshake. Lane and load/store stages use it to know how many beats an instruction occupies and which bytes of the final beat are live.

## Interface
Parameters:
- `XLEN`, 32, scalar width (kept for parameter pass-through only)
- `VLEN`, 16384, vector register length in bits
- `DATA_WIDTH`, 64, datapath beat width in bits; power of two, ≥ 64
- `VLMAX`, VLEN>>3, maximum element count
- `VLEN_B_BITS`, $clog2(VLMAX), element-count index width
- `ENABLE_64_BIT`, 1, when 0, sew=2'b11 is illegal

Ports:
- `clk`  in  1  clock
- `rst`  in  1  reset, asynchronous, active-high
- `start`  in  1  request to sequence one instruction
- `flush`  in  1  synchronous abort of the current sequence
- `avl`  in  VLEN_B_BITS+1  element count, 0..VLMAX
- `sew`  in  2  element width: 00=8b, 01=16b, 10=32b, 11=64b
- `vill`  in  1  configuration illegal
- `busy`  out  1  sequence in progress; `start` is ignored while high
- `out_valid`  out  1  beat presented
- `out_ready`  in  1  consumer accepts beat
- `out_idx`  out  BEAT_W  beat index, from 0
- `out_be`  out  DATA_WIDTH/8  byte enables for this beat
- `out_last`  out  1  final beat of the sequence
- `done`  out  1  one-cycle pulse: sequence completed normally
- `err`  out  1  one-cycle pulse: start was rejected

## Operation
- Derived constants:
  - BPB = DATA_WIDTH/8
  - BC_W = VLEN_B_BITS+4, the byte-count width
  - BEAT_W = BC_W − $clog2(BPB)
- States:
  - IDLE: `busy`=0, `out_valid`=0.
  - RUN: `busy`=1, `out_valid`=1.
- IDLE, `start`=1, `flush`=0:
  - Reject if `vill`=1, or if `sew`=11 and ENABLE_64_BIT=0. Assert `err` next cycle and stay in IDLE.
  - If `avl`=0: assert `done` next cycle and stay in IDLE; no beat is issued.
  - Otherwise latch bytes = avl<<sew (BC_W bits, no overflow) and beats = ceil(bytes/BPB). Set idx=0 and go to RUN.
- RUN:
  - Present `out_idx`=idx.
  - `out_last` = (idx == beats−1).
  - `out_be` is all ones, except on the last beat, where it is the low (bytes mod BPB) bits set; when the remainder is 0 it is all ones.
  - On `out_valid`&`out_ready` with not last: idx+1.
  - On a handshake on the last beat: go to IDLE and pulse `done` next cycle.
- `out_idx`, `out_be` and `out_last` are stable while `out_valid`=1 and `out_ready`=0.
- `flush`=1 (any state): go to IDLE next cycle with no `done` and no `err`. A beat handshaking in the same cycle is still counted as transferred by the consumer. `flush` has priority over `start`.
- Inputs `avl`/`sew` are sampled only at accept. Changes during RUN have no effect.
- Reset values: state IDLE; `busy`, `out_valid`, `out_last`, `done`, `err` = 0; `out_idx` = 0; `out_be` = 0.

## Timing
- `start` accepted in cycle N: first beat has `out_valid`=1 in N+1, or `done`/`err` in N+1 for the zero/illegal cases.
- Throughput is one beat per cycle with `out_ready` held high. An instruction of k beats completes its last handshake in N+k, and `done` is high in N+k+1.
- `busy` falls in the same cycle `done` rises. `start` is accepted in that cycle.
- Back-to-back: `start` held with `out_ready`=1 gives a one-cycle bubble between sequences (the `done` cycle).
- `done` and `err` are never high together. Each is exactly one cycle wide.
- `rst` asserted mid-RUN forces reset values immediately (asynchronously).

## Structure
- Shared package `vseq_pkg` holds:
  - SEW encoding constants (SEW8/16/32/64)
  - state enum {IDLE, RUN}
  - a function returning BEAT_W from DATA_WIDTH/VLEN
- Sub-module `vseq_be_gen`: combinational mask generator. Input is the remainder of bytes mod BPB plus the last flag; output is `out_be`. It is instantiated once.
- Outputs are driven from registers. `out_be`/`out_last` are registered alongside `out_idx`.

## Test plan
DATA_WIDTH=64 (BPB=8) throughout.
- avl=10, sew=01, `out_ready`=1 → 3 beats with idx 0,1,2; be 0xFF,0xFF,0x0F; `out_last` only on idx 2; `done` one cycle after.
- avl=2048, sew=00 → 256 beats, all be=0xFF, last at idx 255. avl=2048, sew=11 → 2048 beats, last idx 2047.
- avl=0 → `done` in N+1, `out_valid` never asserted. `vill`=1 → `err` in N+1, `busy` stays 0. ENABLE_64_BIT=0 with sew=11 → `err`.
- avl=5, sew=10 (20 B) with `out_ready` low for 3 cycles at idx 1 → idx=1 / be=0xFF held stable; last beat be=0x0F.
- `flush` at idx 3 of an 8-beat run → IDLE next cycle, no `done`. A new `start` in the same cycle as `flush` is ignored.
- `rst` pulsed mid-RUN → all outputs 0 immediately. `start` during RUN is ignored (beat count unchanged).
